// File: rtl/snow64_long_div_u16_by_u8_arbiter.sv
// Round-robin arbiter sharing one LongDivU16ByU8 unit among NUM_REQ requesters; 7-cycle nominal grant-to-response.
// Optional SNOW64_LONG_DIV_ARB_ZERO_BYPASS_EN answers b==0 requests directly (1-cycle latency, divider untouched).
module snow64_long_div_u16_by_u8_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_IDX_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*16-1:0]   req_a,
    input  logic [NUM_REQ*8-1:0]    req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [15:0]             resp_data,
    output logic                    resp_div_zero,
    output logic                    busy,
    output logic                    div_start,
    output logic [15:0]             div_a,
    output logic [7:0]              div_b,
    input  logic                    div_data_valid,
    input  logic                    div_can_accept,
    input  logic [15:0]             div_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [REQ_IDX_W-1:0]   owner_q, owner_d;
    logic [15:0]            a_q, a_d;
    logic [7:0]             b_q, b_d;
    logic [15:0]            resp_data_q, resp_data_d;
    logic                   resp_div_zero_q, resp_div_zero_d;

    logic                   found;
    int                     win_i;
    logic                   grant;
    logic [15:0]            sel_a;
    logic [7:0]             sel_b;

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win_i = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win_i = idx;
            end
        end
    end

    assign sel_a = req_a[win_i*16 +: 16];
    assign sel_b = req_b[win_i*8 +: 8];
    assign grant = (state_q == ST_IDLE) && found && div_can_accept && !rst;

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        owner_d         = owner_q;
        a_d             = a_q;
        b_d             = b_q;
        resp_data_d     = resp_data_q;
        resp_div_zero_d = resp_div_zero_q;
        req_ready       = '0;
        resp_valid      = '0;
        div_start       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    req_ready[win_i] = 1'b1;
                    owner_d          = REQ_IDX_W'(win_i);
                    rr_ptr_d         = REQ_IDX_W'((win_i + 1) % NUM_REQ);
                    a_d              = sel_a;
                    b_d              = sel_b;
                    state_d          = ST_ISSUE;
`ifdef SNOW64_LONG_DIV_ARB_ZERO_BYPASS_EN
                    if (sel_b == 8'h00) begin
                        resp_data_d     = 16'hFFFF;
                        resp_div_zero_d = 1'b1;
                        state_d         = ST_RESP;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                div_start = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_data_valid && div_can_accept) begin
                    resp_data_d     = div_data;
                    resp_div_zero_d = (b_q == 8'h00);
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid[owner_q] = 1'b1;
                state_d             = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            owner_q         <= '0;
            a_q             <= '0;
            b_q             <= '0;
            resp_data_q     <= '0;
            resp_div_zero_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            owner_q         <= owner_d;
            a_q             <= a_d;
            b_q             <= b_d;
            resp_data_q     <= resp_data_d;
            resp_div_zero_q <= resp_div_zero_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign div_a         = a_q;
    assign div_b         = b_q;
    assign resp_data     = resp_data_q;
    assign resp_div_zero = resp_div_zero_q;

endmodule

// File: tb/tb_snow64_long_div_u16_by_u8_arbiter.sv
// Directed bench for the divider arbiter with a behavioural 5-cycle divider model.
module tb_snow64_long_div_u16_by_u8_arbiter;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*16-1:0]  req_a;
    logic [NR*8-1:0]   req_b;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [15:0]       resp_data;
    logic              resp_div_zero;
    logic              busy;
    logic              div_start;
    logic [15:0]       div_a;
    logic [7:0]        div_b;
    logic              div_data_valid;
    logic              div_can_accept;
    logic [15:0]       div_data;

    always #5 clk = ~clk;

    snow64_long_div_u16_by_u8_arbiter #(.NUM_REQ(NR), .REQ_IDX_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_div_zero(resp_div_zero), .busy(busy),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_data_valid(div_data_valid), .div_can_accept(div_can_accept),
        .div_data(div_data)
    );

    // Divider model: result ready 5 cycles after the start cycle; no reset.
    logic [2:0]  dcnt = 3'd0;
    logic [15:0] da_m = 16'd0;
    logic [7:0]  db_m = 8'd1;
    logic        force_busy = 1'b0;
    always @(posedge clk) begin
        if (div_start) begin
            dcnt <= 3'd5;
            da_m <= div_a;
            db_m <= div_b;
        end else if (dcnt != 3'd0) begin
            dcnt <= dcnt - 3'd1;
        end
    end
    assign div_data_valid = (dcnt == 3'd1);
    assign div_can_accept = (dcnt <= 3'd1) && !force_busy;
    assign div_data       = (db_m == 8'd0) ? 16'd0 : da_m / {8'd0, db_m};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int starts = 0;
    int g_idx[$], g_cyc[$], r_idx[$], r_cyc[$];
    logic [15:0] r_dat[$];
    logic        r_dz[$];

    function automatic int oh2i(logic [NR-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (req_ready != '0) begin
                g_idx.push_back(oh2i(req_ready));
                g_cyc.push_back(cyc);
            end
            if (resp_valid != '0) begin
                r_idx.push_back(oh2i(resp_valid));
                r_cyc.push_back(cyc);
                r_dat.push_back(resp_data);
                r_dz.push_back(resp_div_zero);
            end
            if (div_start) starts++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grants(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget; k++) begin
            if (g_idx.size() >= n) break;
            @(posedge clk); #1;
        end
        ok = (g_idx.size() >= n);
    endtask

    task automatic wait_resps(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget; k++) begin
            if (r_idx.size() >= n) break;
            @(posedge clk); #1;
        end
        ok = (r_idx.size() >= n);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic        dz;
        int          lat;
        int          st;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int ng, nr, ns;
        bit ok;
        ng = g_idx.size(); nr = r_idx.size(); ns = starts;
        @(posedge clk); #1;
        req_valid[v.idx] = 1'b1;
        req_a[16*v.idx +: 16] = v.a;
        req_b[8*v.idx +: 8] = v.b;
        wait_grants(ng + 1, 30, ok);
        req_valid = '0;
        chk("vec_grant_seen", 32'(ok), 32'd1);
        wait_resps(nr + 1, 30, ok);
        chk("vec_resp_seen", 32'(ok), 32'd1);
        if (ok && g_idx.size() > ng) begin
            chk("vec_grant_idx", 32'(g_idx[ng]), 32'(v.idx));
            chk("vec_resp_idx", 32'(r_idx[nr]), 32'(v.idx));
            chk("vec_resp_data", 32'(r_dat[nr]), 32'(v.q));
            chk("vec_div_zero", 32'(r_dz[nr]), 32'(v.dz));
            chk("vec_latency", 32'(r_cyc[nr] - g_cyc[ng]), 32'(v.lat));
            chk("vec_div_starts", 32'(starts - ns), 32'(v.st));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ng, nr, ns;
        bit ok;
        int exp_q[4];

        vecs[0] = '{idx: 0, a: 16'd1000, b: 8'd7,   q: 16'd142,  dz: 1'b0, lat: 7, st: 1};
        vecs[1] = '{idx: 1, a: 16'hFFFF, b: 8'h01,  q: 16'hFFFF, dz: 1'b0, lat: 7, st: 1};
        vecs[2] = '{idx: 2, a: 16'h00FF, b: 8'hFF,  q: 16'h0001, dz: 1'b0, lat: 7, st: 1};
        vecs[3] = '{idx: 3, a: 16'h0000, b: 8'h05,  q: 16'h0000, dz: 1'b0, lat: 7, st: 1};
        vecs[4] = '{idx: 3, a: 16'd100,  b: 8'd3,   q: 16'd33,   dz: 1'b0, lat: 7, st: 1};
`ifdef SNOW64_LONG_DIV_ARB_ZERO_BYPASS_EN
        vecs[5] = '{idx: 0, a: 16'h1234, b: 8'h00,  q: 16'hFFFF, dz: 1'b1, lat: 1, st: 0};
`else
        vecs[5] = '{idx: 0, a: 16'h1234, b: 8'h00,  q: 16'h0000, dz: 1'b1, lat: 7, st: 1};
`endif
        vecs[6] = '{idx: 1, a: 16'd40000, b: 8'd200, q: 16'd200,  dz: 1'b0, lat: 7, st: 1};

        rst = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready_gated", 32'(req_ready), 32'd0);
        #1 req_valid = '0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_data", 32'(resp_data), 32'd0);
        chk("reset_div_zero", 32'(resp_div_zero), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_div_start", 32'(div_start), 32'd0);
        chk("reset_div_a", 32'(div_a), 32'd0);
        chk("reset_div_b", 32'(div_b), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Contention: all four requesters from reset, served 0,1,2,3.
        do_reset();
        req_a = {16'd300, 16'd65535, 16'd5000, 16'd1000};
        req_b = {8'd3, 8'd255, 8'd50, 8'd7};
        exp_q = '{16'd142, 16'd100, 16'd257, 16'd100};
        ng = g_idx.size(); nr = r_idx.size(); ns = starts;
        req_valid = '1;
        wait_grants(ng + 4, 80, ok);
        req_valid = '0;
        chk("cont_grants_seen", 32'(ok), 32'd1);
        wait_resps(nr + 4, 40, ok);
        chk("cont_resps_seen", 32'(ok), 32'd1);
        if (ok && g_idx.size() >= ng + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("cont_grant_order", 32'(g_idx[ng+i]), 32'(i));
                chk("cont_resp_idx", 32'(r_idx[nr+i]), 32'(i));
                chk("cont_resp_data", 32'(r_dat[nr+i]), 32'(exp_q[i]));
            end
            chk("cont_one_start_per_grant", 32'(starts - ns), 32'd4);
        end

        // Fairness: requesters 1 and 3 alternate.
        do_reset();
        ng = g_idx.size();
        req_valid = 4'b1010;
        wait_grants(ng + 4, 80, ok);
        req_valid = '0;
        chk("fair_grants_seen", 32'(ok), 32'd1);
        if (ok) begin
            chk("fair_g0", 32'(g_idx[ng]),   32'd1);
            chk("fair_g1", 32'(g_idx[ng+1]), 32'd3);
            chk("fair_g2", 32'(g_idx[ng+2]), 32'd1);
            chk("fair_g3", 32'(g_idx[ng+3]), 32'd3);
        end
        wait_resps(r_idx.size() + 1, 20, ok);
        repeat (10) @(posedge clk);
        #1;

        // Reset two cycles after div_start; the in-flight result must vanish.
        ng = g_idx.size(); nr = r_idx.size();
        req_valid[2] = 1'b1;
        req_a[32 +: 16] = 16'd500;
        req_b[16 +: 8] = 8'd10;
        wait_grants(ng + 1, 30, ok);
        req_valid = '0;
        chk("rstw_grant_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        force_busy = 1'b1;
        req_valid[0] = 1'b1;
        req_a[0 +: 16] = 16'd100;
        req_b[0 +: 8] = 8'd4;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstw_busy_cleared", 32'(busy), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("rstw_no_resp", 32'(r_idx.size()), 32'(nr));
        chk("rstw_no_grant_while_busy", 32'(g_idx.size()), 32'(ng + 1));
        force_busy = 1'b0;
        wait_grants(ng + 2, 30, ok);
        req_valid = '0;
        chk("rstw_regrant_seen", 32'(ok), 32'd1);
        wait_resps(nr + 1, 30, ok);
        chk("rstw_resp_seen", 32'(ok), 32'd1);
        if (ok && g_idx.size() >= ng + 2) begin
            chk("rstw_grant_idx", 32'(g_idx[ng+1]), 32'd0);
            chk("rstw_resp_idx", 32'(r_idx[nr]), 32'd0);
            chk("rstw_resp_data", 32'(r_dat[nr]), 32'd25);
            chk("rstw_latency", 32'(r_cyc[nr] - g_cyc[ng+1]), 32'd7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
